// File: rtl/wr_arb.sv
// Round-robin write arbiter: four requesters share one memory port. Each grant
// runs a fixed burst of chip-select setup, LEN write beats, hold and a done pulse.
module wr_arb #(
  parameter int unsigned GAP = 3,   // setup/hold length in cycles, 1..7
  parameter int unsigned LEN = 16   // write beats per burst
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       busy,
  output logic [1:0] id,
  output logic       csn,
  output logic       we,
  output logic [5:0] addr
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StData  = 3'd2,
    StHold  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [3:0] GapLast = 4'(GAP - 1);
  localparam logic [3:0] LenLast = 4'(LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] id_d;
  logic [1:0] last_id_q, last_id_d;
  logic [1:0] sel;
  logic       sel_vld;

  logic [3:0] gnt_d, done_d;
  logic       busy_d, csn_d, we_d;
  logic [5:0] addr_d;

  // Round-robin pick: first active request after the last owner, with wrap.
  always_comb begin
    logic [1:0] cand;
    cand    = '0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_id_q + 2'(i);
      if (!sel_vld && req[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  // Next state, beat/gap counter, owner and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id;
    last_id_d = last_id_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sel_vld) begin
          state_d = StSetup;
          id_d    = sel;
        end
      end
      StSetup: begin
        if (cnt_q == GapLast) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StData: begin
        if (cnt_q == LenLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == GapLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d   = StIdle;
        cnt_d     = '0;
        last_id_d = id;
      end
      default: begin
        // Illegal encoding: back to idle with reset-valued outputs.
        state_d = StIdle;
        cnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so every output leaves a flop.
  always_comb begin
    busy_d = (state_d == StSetup) || (state_d == StData) || (state_d == StHold);
    gnt_d  = busy_d ? (4'b0001 << id_d) : 4'b0000;
    done_d = (state_d == StDone) ? (4'b0001 << id_d) : 4'b0000;
    csn_d  = !busy_d;
    we_d   = (state_d == StData);
    addr_d = we_d ? {id_d, cnt_d} : 6'd0;
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      id        <= '0;
      last_id_q <= 2'd3;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      csn       <= 1'b1;
      we        <= 1'b0;
      addr      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id        <= id_d;
      last_id_q <= last_id_d;
      gnt       <= gnt_d;
      done      <= done_d;
      busy      <= busy_d;
      csn       <= csn_d;
      we        <= we_d;
      addr      <= addr_d;
    end
  end

endmodule

// File: tb/tb_wr_arb.sv
// Bench for wr_arb: a burst-level model predicts grants, a monitor checks
// every output cycle against the expected burst timeline.
module tb_wr_arb;

  localparam int GAP  = 3;
  localparam int LEN  = 16;
  localparam int SPAN = 2 * GAP + LEN;  // offset of the done cycle from grant

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt, done;
  logic       busy, csn, we;
  logic [1:0] id;
  logic [5:0] addr;

  always #5 clk = ~clk;

  wr_arb #(.GAP(GAP), .LEN(LEN)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .id   (id),
    .csn  (csn),
    .we   (we),
    .addr (addr)
  );

  typedef struct {
    int start;
    int id;
  } burst_t;

  int     checks   = 0;
  int     failures = 0;
  burst_t exp_q[$];
  int     obs_ids[$];
  int     cyc      = 0;
  bit     rst_seen = 1'b0;
  int     m_last   = 3;
  int     m_free   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a free arbiter picks the first requester after the last owner;
  // the port is then occupied for the full burst plus one idle cycle.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rst_seen = rst;
      if (rst) begin
        m_last = 3;
        m_free = cyc + 1;
        exp_q.delete();
      end else if (cyc >= m_free && req != 4'b0000) begin
        for (int i = 1; i <= 4; i++) begin
          int c;
          c = (m_last + i) % 4;
          if (req[c]) begin
            exp_q.push_back('{start: cyc, id: c});
            m_last = c;
            m_free = cyc + SPAN + 2;
            break;
          end
        end
      end
    end
  end

  // Monitor: checks outputs once per cycle on the falling edge.
  initial begin
    burst_t     cur;
    bit         in_b = 1'b0;
    int         o;
    logic [3:0] e_gnt, e_done;
    logic       e_busy, e_csn, e_we;
    logic [5:0] e_addr;
    cur = '{start: 0, id: 0};
    forever begin
      @(negedge clk);
      if (cyc == 0) continue;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("we_needs_csn", 32'(we && csn), 32'd0);
      if (rst_seen) begin
        in_b = 1'b0;
        chk("reset_outputs", {14'd0, gnt, done, busy, id, csn, we, addr},
            {14'd0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0});
        continue;
      end
      if (!in_b && gnt != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_cycle", 32'(cyc), 32'(cur.start));
          obs_ids.push_back(int'(id));
          in_b = 1'b1;
        end
      end
      if (!in_b && exp_q.size() > 0 && exp_q[0].start <= cyc) begin
        chk("missed_grant", 32'(gnt), 32'(4'b0001 << exp_q[0].id));
        void'(exp_q.pop_front());
      end
      e_gnt  = 4'd0;
      e_done = 4'd0;
      e_busy = 1'b0;
      e_csn  = 1'b1;
      e_we   = 1'b0;
      e_addr = 6'd0;
      if (in_b) begin
        o = cyc - cur.start;
        if (o < SPAN) begin
          e_gnt  = 4'(4'b0001 << cur.id);
          e_busy = 1'b1;
          e_csn  = 1'b0;
          if (o >= GAP && o < GAP + LEN) begin
            e_we   = 1'b1;
            e_addr = {2'(cur.id), 4'(o - GAP)};
          end
          chk("owner_id", 32'(id), 32'(cur.id));
        end else begin
          e_done = 4'(4'b0001 << cur.id);
          in_b   = 1'b0;
        end
      end
      chk("outputs", {15'd0, gnt, done, busy, csn, we, addr},
          {15'd0, e_gnt, e_done, e_busy, e_csn, e_we, e_addr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs_ids.size() < n && k < 400) begin
      tick(1);
      k++;
    end
    chk("grant_count", 32'(obs_ids.size()), 32'(n));
  endtask

  // Stimulus: directed scenarios, then randomized traffic with sporadic resets.
  initial begin
    int k;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Single request from requester 0.
    obs_ids.delete();
    req = 4'b0001;
    tick(1);
    req = 4'b0000;
    wait_obs(1);
    tick(30);
    if (obs_ids.size() > 0) chk("first_winner", 32'(obs_ids[0]), 32'd0);

    // All requesting: round-robin order 0,1,2,3,0 (pointer is at 0 now, so 1 first).
    // Re-run from a reset to get the 0,1,2,3,0 order from the reset pointer.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    obs_ids.delete();
    req = 4'b1111;
    wait_obs(5);
    req = 4'b0000;
    tick(30);
    if (obs_ids.size() >= 5) begin
      chk("rr_0", 32'(obs_ids[0]), 32'd0);
      chk("rr_1", 32'(obs_ids[1]), 32'd1);
      chk("rr_2", 32'(obs_ids[2]), 32'd2);
      chk("rr_3", 32'(obs_ids[3]), 32'd3);
      chk("rr_4", 32'(obs_ids[4]), 32'd0);
    end

    // Requester 1 completes, then 1 and 2 arrive together: 2 wins first.
    obs_ids.delete();
    req = 4'b0010;
    tick(1);
    req = 4'b0000;
    tick(30);
    obs_ids.delete();
    req = 4'b0110;
    wait_obs(2);
    req = 4'b0000;
    tick(30);
    if (obs_ids.size() >= 2) begin
      chk("tie_first", 32'(obs_ids[0]), 32'd2);
      chk("tie_second", 32'(obs_ids[1]), 32'd1);
    end

    // Reset during data beat 5 aborts the burst; pointer restarts at 0.
    req = 4'b0001;
    k = 0;
    while (!(we && addr[3:0] == 4'd5) && k < 100) begin
      tick(1);
      k++;
    end
    chk("reached_beat5", 32'(we && addr[3:0] == 4'd5), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    obs_ids.delete();
    req = 4'b1001;
    wait_obs(1);
    req = 4'b0000;
    tick(30);
    if (obs_ids.size() > 0) chk("after_reset_winner", 32'(obs_ids[0]), 32'd0);

    // Requester 3 drops its request during setup; burst still completes.
    obs_ids.delete();
    req = 4'b1000;
    tick(2);
    req = 4'b0000;
    tick(30);
    chk("drop_grant_count", 32'(obs_ids.size()), 32'd1);
    if (obs_ids.size() > 0) chk("drop_winner", 32'(obs_ids[0]), 32'd3);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    req = 4'b0000;
    tick(30);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
